imm_gen_stage: RTL and testbench
================================

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter XLEN, default 32, immediate/PC/target datapath width; legal values 32 and 64 only.
REQ-002 Parameter SHAMT_ZEXT, default 1, shift-immediate handling for OP-IMM/OP-IMM-32 shifts: 1 = zero-extended shamt, 0 = plain I-type sign extension.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush_i  input  1  discards all held entries.
REQ-006 in_valid_i  input  1  upstream holds a valid instruction.
REQ-007 in_ready_o  output  1  stage can accept an instruction this cycle.
REQ-008 inst_i  input  32  instruction word.
REQ-009 pc_i  input  XLEN  instruction PC.
REQ-010 out_valid_o  output  1  output entry valid.
REQ-011 out_ready_i  input  1  downstream accepts the output entry.
REQ-012 imm_o  output  XLEN  decoded, sign-/zero-extended immediate.
REQ-013 fmt_o  output  3  immediate format code: NONE, I, S, B, U, J, SHAMT.
REQ-014 target_o  output  XLEN  pc + imm, modulo 2^XLEN.
REQ-015 pc_o  output  XLEN  PC carried with the entry.

Function
REQ-016 Decode by opcode: JAL J; JALR, LOAD, OP-IMM, SYSTEM I; STORE S; BRANCH B; LUI, AUIPC U; OP-IMM-32 I only when XLEN=64; all other opcodes NONE with imm 0.
REQ-017 I: sext(inst[31:20]); S: sext({inst[31:25],inst[11:7]}); B: sext({inst[31],inst[7],inst[30:25],inst[11:8],0}); J: sext({inst[31],inst[19:12],inst[20],inst[30:21],0}); U: sext({inst[31:12],12'h0}) to XLEN.
REQ-018 With SHAMT_ZEXT=1, OP-IMM funct3 001/101 yields fmt SHAMT, imm = zext(inst[24:20]) for XLEN=32 or zext(inst[25:20]) for XLEN=64; OP-IMM-32 shifts use inst[24:20].
REQ-019 target = pc + imm computed for every format, truncated to XLEN.
REQ-020 Transfer in occurs when in_valid_i and in_ready_o are both 1; transfer out occurs when out_valid_o and out_ready_i are both 1.
REQ-021 Latency: an accepted instruction appears on outputs the next cycle if the stage was empty or draining.
REQ-022 Storage is a 2-entry skid buffer (main + skid); entries leave strictly in acceptance order.
REQ-023 in_ready_o = 1 iff the skid entry is empty (registered, not combinationally dependent on out_ready_i).
REQ-024 Outputs stay stable while out_valid_o=1 and out_ready_i=0.
REQ-025 Simultaneous transfer in and out with one entry held: occupancy unchanged, new entry follows.
REQ-026 flush_i=1: both entries invalidated next cycle, input that cycle dropped, out_valid_o=0 and in_ready_o=1 next cycle; flush dominates any handshake.
REQ-027 Data outputs are don't-care while out_valid_o=0 but SHALL be driven (no X).

Reset
REQ-028 rst_n=0 at a clock edge clears both entries: out_valid_o=0, in_ready_o=1, imm_o/target_o/pc_o=0, fmt_o=NONE on the following cycle.
REQ-029 Reset mid-stall loses held entries without emitting them; reset overrides flush and handshakes.

Structure
REQ-030 Package imm_pkg holds the fmt enum, opcode constants and funct3 shift constants.
REQ-031 Combinational decode is sub-module imm_decode (inst, pc in; imm, fmt, target out), parameterised by XLEN and SHAMT_ZEXT; imm_gen_stage holds the skid buffer and handshake.
REQ-032 XLEN outside {32,64} SHALL fail elaboration.

Verification
REQ-033 XLEN=32, inst 0xFFDFF0EF (jal x1,-4), pc 0x100 -> next cycle imm 0xFFFFFFFC, fmt J, target 0x000000FC.
REQ-034 inst 0x123450B7 (lui) -> imm 0x12345000, fmt U; XLEN=64, inst 0x800000B7 -> imm 0xFFFFFFFF80000000.
REQ-035 inst 0x4050D093 (srai x1,x1,5), SHAMT_ZEXT=1 -> imm 5, fmt SHAMT; SHAMT_ZEXT=0 -> imm 0x405, fmt I; inst 0x002081B3 -> imm 0, fmt NONE.
REQ-036 in_valid_i held 1 with 4 instructions, out_ready_i=0 for 3 cycles -> in_ready_o falls after 2 accepted, outputs stable, all 4 emitted in order after release, none lost or duplicated.
REQ-037 flush_i pulsed while both entries full -> next cycle out_valid_o=0, in_ready_o=1, flushed entries never emitted.
REQ-038 rst_n low one cycle mid-stall -> next cycle out_valid_o=0, imm_o=0, fmt_o=NONE, in_ready_o=1; stream resumes correctly afterward.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation stage: format codes,
// RV opcode values and the funct3 codes that mark immediate shifts.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'h03;
  localparam logic [6:0] OPC_OP_IMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC     = 7'h17;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
  localparam logic [6:0] OPC_STORE     = 7'h23;
  localparam logic [6:0] OPC_LUI       = 7'h37;
  localparam logic [6:0] OPC_BRANCH    = 7'h63;
  localparam logic [6:0] OPC_JALR      = 7'h67;
  localparam logic [6:0] OPC_JAL       = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM    = 7'h73;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == F3_SLLI) || (f3 == F3_SRXI);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Purely combinational immediate decoder: picks the format from the opcode,
// extends the immediate to XLEN and forms pc + imm.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHAMT_ZEXT = 1
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] target
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("imm_decode: XLEN must be 32 or 64");
  end

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh, imm_sh32;
  imm_fmt_e        fmt_e;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];

  // Sign-extending size casts keep every format correct for both XLEN values.
  assign imm_i    = XLEN'($signed(inst[31:20]));
  assign imm_s    = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b    = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_j    = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  assign imm_u    = XLEN'($signed({inst[31:12], 12'h000}));
  assign imm_sh   = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
  assign imm_sh32 = XLEN'(inst[24:20]);

  always_comb begin
    fmt_e = FMT_NONE;
    imm   = '0;
    case (opcode)
      OPC_JAL: begin
        fmt_e = FMT_J;
        imm   = imm_j;
      end
      OPC_JALR, OPC_LOAD, OPC_SYSTEM: begin
        fmt_e = FMT_I;
        imm   = imm_i;
      end
      OPC_OP_IMM: begin
        if (SHAMT_ZEXT != 0 && is_shift_f3(f3)) begin
          fmt_e = FMT_SHAMT;
          imm   = imm_sh;
        end else begin
          fmt_e = FMT_I;
          imm   = imm_i;
        end
      end
      OPC_OP_IMM_32: begin
        // The word-sized immediate ops only exist on RV64.
        if (XLEN == 64) begin
          if (SHAMT_ZEXT != 0 && is_shift_f3(f3)) begin
            fmt_e = FMT_SHAMT;
            imm   = imm_sh32;
          end else begin
            fmt_e = FMT_I;
            imm   = imm_i;
          end
        end
      end
      OPC_STORE: begin
        fmt_e = FMT_S;
        imm   = imm_s;
      end
      OPC_BRANCH: begin
        fmt_e = FMT_B;
        imm   = imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_e = FMT_U;
        imm   = imm_u;
      end
      default: begin
        fmt_e = FMT_NONE;
        imm   = '0;
      end
    endcase
  end

  assign fmt    = fmt_e;
  assign target = pc + imm;

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decodes on entry and holds results in
// a two-entry skid buffer (main drives the outputs, skid absorbs one stall).
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHAMT_ZEXT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] dec_imm, dec_target;
  logic [2:0]      dec_fmt;

  imm_decode #(
    .XLEN      (XLEN),
    .SHAMT_ZEXT(SHAMT_ZEXT)
  ) u_decode (
    .inst  (inst_i),
    .pc    (pc_i),
    .imm   (dec_imm),
    .fmt   (dec_fmt),
    .target(dec_target)
  );

  logic            main_valid, skid_valid;
  logic [XLEN-1:0] main_imm, main_target, main_pc;
  logic [XLEN-1:0] skid_imm, skid_target, skid_pc;
  logic [2:0]      main_fmt, skid_fmt;
  logic            main_free;

  // Main can take new data when it is empty or its entry leaves this cycle.
  assign main_free = !main_valid || out_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      main_imm    <= '0;
      main_target <= '0;
      main_pc     <= '0;
      main_fmt    <= FMT_NONE;
      skid_imm    <= '0;
      skid_target <= '0;
      skid_pc     <= '0;
      skid_fmt    <= FMT_NONE;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      // A held skid entry is older than anything upstream (in_ready is low).
      if (skid_valid) begin
        main_valid  <= 1'b1;
        main_imm    <= skid_imm;
        main_fmt    <= skid_fmt;
        main_target <= skid_target;
        main_pc     <= skid_pc;
        skid_valid  <= 1'b0;
      end else begin
        main_valid <= in_valid_i;
        if (in_valid_i) begin
          main_imm    <= dec_imm;
          main_fmt    <= dec_fmt;
          main_target <= dec_target;
          main_pc     <= pc_i;
        end
      end
    end else if (in_valid_i && !skid_valid) begin
      skid_valid  <= 1'b1;
      skid_imm    <= dec_imm;
      skid_fmt    <= dec_fmt;
      skid_target <= dec_target;
      skid_pc     <= pc_i;
    end
  end

  assign in_ready_o  = !skid_valid;
  assign out_valid_o = main_valid;
  assign imm_o       = main_imm;
  assign fmt_o       = main_fmt;
  assign target_o    = main_target;
  assign pc_o        = main_pc;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: three configurations share one stimulus stream and
// are scored against a queue-based model of the stage contents.
module tb_imm_gen_stage;

  localparam logic [2:0] TB_NONE = 3'd0, TB_I = 3'd1, TB_S = 3'd2, TB_B = 3'd3,
                         TB_U = 3'd4, TB_J = 3'd5, TB_SHAMT = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n, flush_i, in_valid_i, out_ready_i;
  logic [31:0] inst_i;
  logic [63:0] pc64;

  logic        rdy32, vld32, rdy64, vld64, rdyz, vldz;
  logic [31:0] imm32, tgt32, pco32, immz, tgtz, pcoz;
  logic [63:0] imm64, tgt64, pco64;
  logic [2:0]  fmt32, fmt64, fmtz;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .SHAMT_ZEXT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(rdy32), .inst_i(inst_i), .pc_i(pc64[31:0]),
    .out_valid_o(vld32), .out_ready_i(out_ready_i), .imm_o(imm32),
    .fmt_o(fmt32), .target_o(tgt32), .pc_o(pco32));

  imm_gen_stage #(.XLEN(64), .SHAMT_ZEXT(1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(rdy64), .inst_i(inst_i), .pc_i(pc64),
    .out_valid_o(vld64), .out_ready_i(out_ready_i), .imm_o(imm64),
    .fmt_o(fmt64), .target_o(tgt64), .pc_o(pco64));

  imm_gen_stage #(.XLEN(32), .SHAMT_ZEXT(0)) u_dutz (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(rdyz), .inst_i(inst_i), .pc_i(pc64[31:0]),
    .out_valid_o(vldz), .out_ready_i(out_ready_i), .imm_o(immz),
    .fmt_o(fmtz), .target_o(tgtz), .pc_o(pcoz));

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } entry_t;

  entry_t q[$];
  bit     zeroFlag;
  bit     lastAccepted;
  int     popCount;
  int     nChecks = 0;
  int     nPass   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    else
      nPass++;
  endtask

  // Reference decode straight from the ISA bit layouts using signed arithmetic.
  function automatic void refDecode(input int xlen, input int zext, input logic [31:0] inst,
                                    input logic [63:0] pc, output logic [63:0] imm,
                                    output logic [2:0] fmt, output logic [63:0] tgt);
    longint      s, hi;
    logic [63:0] mask;
    logic [6:0]  opc;
    logic [2:0]  f3;
    bit          isShift;
    s = longint'($signed(inst));
    opc = inst[6:0];
    f3 = inst[14:12];
    isShift = (f3 == 3'd1) || (f3 == 3'd5);
    imm = 64'd0;
    fmt = TB_NONE;
    if (opc == 7'h6F) begin
      hi = s >>> 31;
      imm = (64'(hi) << 20) | (64'(inst[19:12]) << 12) | (64'(inst[20]) << 11) | (64'(inst[30:21]) << 1);
      fmt = TB_J;
    end else if (opc == 7'h67 || opc == 7'h03 || opc == 7'h73 ||
                 ((opc == 7'h13 || (opc == 7'h1B && xlen == 64)) && !(zext != 0 && isShift))) begin
      hi = s >>> 20;
      imm = 64'(hi);
      fmt = TB_I;
    end else if (opc == 7'h13) begin
      imm = (xlen == 64) ? 64'(inst[25:20]) : 64'(inst[24:20]);
      fmt = TB_SHAMT;
    end else if (opc == 7'h1B && xlen == 64) begin
      imm = 64'(inst[24:20]);
      fmt = TB_SHAMT;
    end else if (opc == 7'h23) begin
      hi = s >>> 25;
      imm = (64'(hi) << 5) | 64'(inst[11:7]);
      fmt = TB_S;
    end else if (opc == 7'h63) begin
      hi = s >>> 31;
      imm = (64'(hi) << 12) | (64'(inst[7]) << 11) | (64'(inst[30:25]) << 5) | (64'(inst[11:8]) << 1);
      fmt = TB_B;
    end else if (opc == 7'h37 || opc == 7'h17) begin
      hi = s >>> 12;
      imm = 64'(hi) << 12;
      fmt = TB_U;
    end
    mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    imm = imm & mask;
    tgt = ((pc & mask) + imm) & mask;
  endfunction

  task automatic checkDut(input string nm, input int xlen, input int zext, input logic rdy,
                          input logic vld, input logic [63:0] imm, input logic [2:0] fmt,
                          input logic [63:0] tgt, input logic [63:0] pco);
    logic [63:0] ei, et, mask;
    logic [2:0]  ef;
    mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    checkOutput({nm, "_in_ready"}, 64'(rdy), 64'(q.size() < 2));
    checkOutput({nm, "_out_valid"}, 64'(vld), 64'(q.size() > 0));
    checkOutput({nm, "_driven"}, 64'($isunknown({imm, fmt, tgt, pco})), 64'd0);
    if (q.size() > 0) begin
      refDecode(xlen, zext, q[0].inst, q[0].pc, ei, ef, et);
      checkOutput({nm, "_imm"}, imm, ei);
      checkOutput({nm, "_fmt"}, 64'(fmt), 64'(ef));
      checkOutput({nm, "_target"}, tgt, et);
      checkOutput({nm, "_pc"}, pco, q[0].pc & mask);
    end else if (zeroFlag) begin
      checkOutput({nm, "_rst_imm"}, imm, 64'd0);
      checkOutput({nm, "_rst_fmt"}, 64'(fmt), 64'(TB_NONE));
      checkOutput({nm, "_rst_target"}, tgt, 64'd0);
      checkOutput({nm, "_rst_pc"}, pco, 64'd0);
    end
  endtask

  task automatic modelStep();
    int sz;
    entry_t e;
    zeroFlag = 1'b0;
    lastAccepted = 1'b0;
    if (!rst_n) begin
      q.delete();
      zeroFlag = 1'b1;
    end else if (flush_i) begin
      q.delete();
    end else begin
      sz = q.size();
      if (sz > 0 && out_ready_i) begin
        void'(q.pop_front());
        popCount++;
      end
      if (in_valid_i && sz < 2) begin
        e.inst = inst_i;
        e.pc = pc64;
        q.push_back(e);
        lastAccepted = 1'b1;
      end
    end
  endtask

  // Drives one cycle of inputs, advances the model and scores all three DUTs.
  task automatic applyStimulus(input bit rstn, input bit flush, input bit vin, input bit ordy,
                               input logic [31:0] inst, input logic [63:0] pc);
    rst_n = rstn;
    flush_i = flush;
    in_valid_i = vin;
    out_ready_i = ordy;
    inst_i = inst;
    pc64 = pc;
    @(negedge clk);
    modelStep();
    checkDut("x32", 32, 1, rdy32, vld32, {32'd0, imm32}, fmt32, {32'd0, tgt32}, {32'd0, pco32});
    checkDut("x64", 64, 1, rdy64, vld64, imm64, fmt64, tgt64, pco64);
    checkDut("x32z", 32, 0, rdyz, vldz, {32'd0, immz}, fmtz, {32'd0, tgtz}, {32'd0, pcoz});
  endtask

  function automatic logic [31:0] randInst();
    logic [6:0]  opcs [13];
    logic [31:0] r, r2;
    opcs = '{7'h03, 7'h13, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h1B};
    r = $urandom();
    r2 = $urandom();
    if (r2[3:0] == 4'hF) return {r[31:7], r2[10:4]};
    return {r[31:7], opcs[$urandom_range(0, 12)]};
  endfunction

  function automatic logic [63:0] randPc();
    logic [31:0] a, b;
    a = $urandom();
    b = $urandom();
    return {a, b};
  endfunction

  initial begin
    logic [31:0] stream [4];
    int idx, base;

    popCount = 0;
    applyStimulus(0, 0, 0, 0, 32'd0, 64'd0);
    applyStimulus(0, 1, 1, 1, 32'h0000_0013, 64'd4);

    applyStimulus(1, 0, 1, 1, 32'hFFDF_F0EF, 64'h100);
    checkOutput("jal_imm", {32'd0, imm32}, 64'hFFFF_FFFC);
    checkOutput("jal_fmt", 64'(fmt32), 64'(TB_J));
    checkOutput("jal_target", {32'd0, tgt32}, 64'h0000_00FC);

    applyStimulus(1, 0, 1, 1, 32'h1234_50B7, 64'h200);
    checkOutput("lui_imm", {32'd0, imm32}, 64'h1234_5000);
    checkOutput("lui_fmt", 64'(fmt32), 64'(TB_U));
    applyStimulus(1, 0, 1, 1, 32'h8000_00B7, 64'h204);
    checkOutput("lui64_imm", imm64, 64'hFFFF_FFFF_8000_0000);

    applyStimulus(1, 0, 1, 1, 32'h4050_D093, 64'h208);
    checkOutput("srai_imm", {32'd0, imm32}, 64'd5);
    checkOutput("srai_fmt", 64'(fmt32), 64'(TB_SHAMT));
    checkOutput("srai_i_imm", {32'd0, immz}, 64'h405);
    checkOutput("srai_i_fmt", 64'(fmtz), 64'(TB_I));

    applyStimulus(1, 0, 1, 1, 32'h0020_81B3, 64'h20C);
    checkOutput("add_imm", {32'd0, imm32}, 64'd0);
    checkOutput("add_fmt", 64'(fmt32), 64'(TB_NONE));
    applyStimulus(1, 0, 0, 1, 32'd0, 64'd0);

    $display("[TB] stall with four queued instructions");
    stream = '{32'h0040_0093, 32'h0081_2023, 32'hFE00_0EE3, 32'h0000_1137};
    idx = 0;
    base = popCount;
    for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
      applyStimulus(1, 0, idx < 4, c >= 3, (idx < 4) ? stream[idx] : 32'd0, 64'h1000 + 64'(4 * idx));
      if (lastAccepted) idx++;
      if (c == 2) begin
        checkOutput("stall_accepted", 64'(idx), 64'd2);
        checkOutput("stall_ready_low", 64'(rdy32), 64'd0);
      end
    end
    checkOutput("stall_emitted", 64'(popCount - base), 64'd4);

    $display("[TB] flush with both entries full");
    applyStimulus(1, 0, 1, 0, 32'h0010_0093, 64'h2000);
    applyStimulus(1, 0, 1, 0, 32'h0020_0093, 64'h2004);
    applyStimulus(1, 1, 1, 1, 32'h0030_0093, 64'h2008);
    checkOutput("flush_valid", 64'(vld32), 64'd0);
    checkOutput("flush_ready", 64'(rdy32), 64'd1);
    applyStimulus(1, 0, 0, 1, 32'd0, 64'd0);
    applyStimulus(1, 0, 1, 1, 32'h0040_0093, 64'h200C);
    applyStimulus(1, 0, 0, 1, 32'd0, 64'd0);

    $display("[TB] reset while stalled");
    applyStimulus(1, 0, 1, 0, 32'h0050_0093, 64'h3000);
    applyStimulus(1, 0, 1, 0, 32'h0060_0093, 64'h3004);
    applyStimulus(0, 1, 1, 1, 32'h0070_0093, 64'h3008);
    checkOutput("rst_valid", 64'(vld32), 64'd0);
    checkOutput("rst_imm", {32'd0, imm32}, 64'd0);
    checkOutput("rst_fmt", 64'(fmt32), 64'(TB_NONE));
    checkOutput("rst_ready", 64'(rdy32), 64'd1);
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 0, 1, i[0], 32'h0000_0013 | (32'(i) << 20), 64'h3100 + 64'(4 * i));

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    randInst(), randPc());

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
